// File: rtl/result_frame_collector.sv
// result_frame_collector
//
// Captures two independent result streams into a two-bank frame buffer and,
// once both halves are complete, replays the whole frame in address order.
//   lane 1 (result1/output_result1) -> bank0, frame addresses 0..HALF-1
//   lane 2 (result2/output_result2) -> bank1, frame addresses HALF..2*HALF-1
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           arms a new frame (IDLE only)
//   result1/2       lane strobes with their data words
//   busy            high while collecting or draining
//   frame_done      one-cycle pulse after the final write of a frame
//   overflow        sticky: a strobe arrived that could not be stored
//   rd_valid/ready  read handshake; rd_data/rd_addr/rd_last describe the word
module result_frame_collector #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned HALF   = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              result1,
    input  logic [DATA_W-1:0] output_result1,
    input  logic              result2,
    input  logic [DATA_W-1:0] output_result2,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last
);

    localparam int unsigned OFF_W = ADDR_W - 1;
    localparam int unsigned CNT_W = ADDR_W;
    localparam logic [CNT_W-1:0]  HalfCnt  = CNT_W'(HALF);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(2 * HALF - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic              overflow_q, overflow_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] drain_ptr_q, drain_ptr_d;
    logic              fetch_done_q, fetch_done_d;
    logic              ram_vld_q, ram_vld_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;

    logic              we0, we1, issue, load_out, handshake;
    logic [DATA_W-1:0] ram_word;

    // Frame storage; contents survive reset.
    logic [DATA_W-1:0] bank0_q [HALF];
    logic [DATA_W-1:0] bank1_q [HALF];
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    always_ff @(posedge clk) begin
        if (we0) bank0_q[cnt1_q[OFF_W-1:0]] <= output_result1;
        if (issue) rdata0_q <= bank0_q[drain_ptr_q[OFF_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (we1) bank1_q[cnt2_q[OFF_W-1:0]] <= output_result2;
        if (issue) rdata1_q <= bank1_q[drain_ptr_q[OFF_W-1:0]];
    end

    // Bank select follows the address of the word held in the read registers.
    assign ram_word = ram_addr_q[ADDR_W-1] ? rdata1_q : rdata0_q;

    always_comb begin
        state_d      = state_q;
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        drain_ptr_d  = drain_ptr_q;
        fetch_done_d = fetch_done_q;
        ram_vld_d    = ram_vld_q;
        ram_addr_d   = ram_addr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        out_last_d   = out_last_q;
        we0          = 1'b0;
        we1          = 1'b0;
        issue        = 1'b0;
        load_out     = 1'b0;
        handshake    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt1_d     = '0;
                    cnt2_d     = '0;
                    overflow_d = 1'b0;
                    state_d    = StCollect;
                end
                if (result1 || result2) overflow_d = 1'b1;
            end

            StCollect: begin
                if (result1) begin
                    if (cnt1_q < HalfCnt) begin
                        we0    = 1'b1;
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (result2) begin
                    if (cnt2_q < HalfCnt) begin
                        we1    = 1'b1;
                        cnt2_d = cnt2_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (cnt1_d == HalfCnt && cnt2_d == HalfCnt) begin
                    state_d      = StDrain;
                    frame_done_d = 1'b1;
                end
            end

            StDrain: begin
                if (result1 || result2) overflow_d = 1'b1;
                handshake = out_valid_q && rd_ready;
                // Refill the output stage whenever it empties or is consumed, and keep
                // one read in flight behind it so a stalled consumer loses nothing.
                load_out  = (!out_valid_q || handshake) && ram_vld_q;
                issue     = !fetch_done_q && (!ram_vld_q || load_out);

                if (load_out) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ram_word;
                    out_addr_d  = ram_addr_q;
                    out_last_d  = (ram_addr_q == LastAddr);
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                end

                ram_vld_d = issue || (ram_vld_q && !load_out);
                if (issue) begin
                    ram_addr_d  = drain_ptr_q;
                    drain_ptr_d = drain_ptr_q + ADDR_W'(1);
                    if (drain_ptr_q == LastAddr) fetch_done_d = 1'b1;
                end

                if (handshake && out_last_q) begin
                    state_d      = StIdle;
                    out_valid_d  = 1'b0;
                    ram_vld_d    = 1'b0;
                    fetch_done_d = 1'b0;
                    drain_ptr_d  = '0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            drain_ptr_q  <= '0;
            fetch_done_q <= 1'b0;
            ram_vld_q    <= 1'b0;
            ram_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            drain_ptr_q  <= drain_ptr_d;
            fetch_done_q <= fetch_done_d;
            ram_vld_q    <= ram_vld_d;
            ram_addr_q   <= ram_addr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            out_last_q   <= out_last_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign rd_valid   = out_valid_q;
    assign rd_data    = out_data_q;
    assign rd_addr    = out_addr_q;
    assign rd_last    = out_valid_q && out_last_q;

endmodule

// File: tb/tb_result_frame_collector.sv
// Bench for result_frame_collector: directed scenarios plus randomized frames,
// checked every cycle against a behavioural frame model.
module tb_result_frame_collector;

    localparam int DW = 13;
    localparam int AW = 12;
    localparam int H  = 2048;

    logic          clk = 1'b0;
    logic          rst, start, result1, result2, rd_ready;
    logic [DW-1:0] output_result1, output_result2;
    logic          busy, frame_done, overflow, rd_valid, rd_last;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_addr;

    always #5 clk = ~clk;

    result_frame_collector #(.DATA_W(DW), .ADDR_W(AW), .HALF(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .result1        (result1),
        .output_result1 (output_result1),
        .result2        (result2),
        .output_result2 (output_result2),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_addr        (rd_addr),
        .rd_last        (rd_last)
    );

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;
    int pin_addr = -1;
    logic [DW-1:0] pin_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 collecting, 2 draining
    logic [DW-1:0] m_mem [2*H];
    int m_mode = 0, m_c1 = 0, m_c2 = 0, m_lat = 0, m_ptr = 0;
    bit m_ovf = 0, m_fd = 0, m_valid = 0, m_known = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_c1 = 0; m_c2 = 0; m_ovf = 0; m_fd = 0;
            m_valid = 0; m_ptr = 0; m_lat = 0; m_known = 1;
        end else begin
            m_fd = 0;
            case (m_mode)
                0: begin
                    if (start) begin m_c1 = 0; m_c2 = 0; m_ovf = 0; m_mode = 1; end
                    if (result1 || result2) m_ovf = 1;
                end
                1: begin
                    if (result1) begin
                        if (m_c1 < H) begin m_mem[m_c1] = output_result1; m_c1++; end
                        else m_ovf = 1;
                    end
                    if (result2) begin
                        if (m_c2 < H) begin m_mem[H + m_c2] = output_result2; m_c2++; end
                        else m_ovf = 1;
                    end
                    if (m_c1 == H && m_c2 == H) begin
                        m_mode = 2; m_fd = 1; m_lat = 1; m_valid = 0;
                    end
                end
                default: begin
                    if (result1 || result2) m_ovf = 1;
                    if (m_valid) begin
                        if (rd_ready) begin
                            if (m_ptr == 2*H - 1) begin m_mode = 0; m_valid = 0; end
                            else m_ptr++;
                        end
                    end else if (m_lat > 0) begin
                        m_lat--;
                    end else begin
                        m_valid = 1; m_ptr = 0;
                    end
                end
            endcase
        end
    end

    // Single compare process: all outputs are registered, so sample mid-cycle.
    always @(negedge clk) begin
        if (m_known) begin
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            chk("rd_last", 32'(rd_last), 32'(m_valid && m_ptr == 2*H - 1));
            if (m_valid) begin
                chk("rd_addr", 32'(rd_addr), 32'(m_ptr));
                chk("rd_data", 32'(rd_data), 32'(m_mem[m_ptr]));
            end
        end
        if (frame_done === 1'b1) fd_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic quiet();
        start = 0; result1 = 0; result2 = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_valid"}, 32'(rd_valid), 0);
        chk({tag, "_data"}, 32'(rd_data), 0);
        chk({tag, "_addr"}, 32'(rd_addr), 0);
        chk({tag, "_last"}, 32'(rd_last), 0);
    endtask

    task automatic start_frame();
        quiet(); start = 1; fd_seen = 0;
        step();
        start = 0;
    endtask

    // Both lanes on the same cycles; data k and 2048+k (or random).
    task automatic fill_sim(input bit rnd);
        for (int k = 0; k < H; k++) begin
            result1 = 1; output_result1 = rnd ? DW'($urandom) : DW'(k);
            result2 = 1; output_result2 = rnd ? DW'($urandom) : DW'(H + k);
            step();
        end
        quiet();
    endtask

    task automatic run_until_idle(input int ready_pct);
        int n = 0;
        quiet();
        do begin
            rd_ready = ($urandom_range(99) < ready_pct);
            step();
            if (pin_addr >= 0 && rd_valid && rd_addr == AW'(pin_addr)) begin
                chk("pinned_word", 32'(rd_data), 32'(pin_data));
                pin_addr = -1;
            end
            n++;
        end while (busy && n < 20000);
        if (busy) chk("drain_timeout", 32'(busy), 0);
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        rd_ready = 1;
        step();
        while (!(rd_valid && rd_addr == AW'(a)) && n < 10000) begin step(); n++; end
        chk("wait_addr_reached", 32'(rd_addr), 32'(a));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst = 1; quiet(); rd_ready = 0;
        output_result1 = '0; output_result2 = '0;
        for (int i = 0; i < 2*H; i++) m_mem[i] = '0;
        repeat (3) step();
        chk_zero("reset0");
        rst = 0;

        // Stray strobe while idle.
        result1 = 1; step(); quiet();
        chk("idle_strobe_ovf", 32'(overflow), 1);

        // Full frame, both lanes together, drained at full rate.
        start_frame();
        chk("start_clears_ovf", 32'(overflow), 0);
        fill_sim(0);
        pin_addr = 2*H - 1; pin_data = DW'(2*H - 1);
        run_until_idle(100);
        chk("sim_fd_pulses", 32'(fd_seen), 1);
        chk("sim_busy_after", 32'(busy), 0);

        // Skewed lanes, with a 3-cycle reset mid-stream first.
        start_frame();
        for (int i = 0; i < 500; i++) begin
            result2 = 1; output_result2 = DW'($urandom); step();
        end
        quiet(); rst = 1; repeat (3) step(); rst = 0;
        chk_zero("reset_mid");
        result2 = 1; step(); quiet();
        chk("idle_strobe_ovf2", 32'(overflow), 1);
        start_frame();
        begin
            int n1 = 0, n2 = 0, i = 0;
            while (n1 < H && i < 10000) begin
                result2 = (n2 < H); output_result2 = DW'($urandom);
                result1 = (i % 3 == 0); output_result1 = DW'($urandom);
                step();
                if (result1) n1++;
                if (result2) n2++;
                i++;
            end
        end
        run_until_idle(90);
        chk("skew_fd_pulses", 32'(fd_seen), 1);

        // Backpressure at address 100.
        start_frame();
        fill_sim(0);
        wait_addr(100);
        rd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_addr", 32'(rd_addr), 100);
            chk("bp_hold_data", 32'(rd_data), 100);
        end
        run_until_idle(50);

        // Overflow on lane 1.
        start_frame();
        for (int k = 0; k < H; k++) begin
            result1 = 1; output_result1 = DW'(k); step();
        end
        output_result1 = DW'(13'h1FFF); step(); quiet();
        chk("lane1_overflow", 32'(overflow), 1);
        for (int k = 0; k < H; k++) begin
            result2 = 1; output_result2 = DW'(H + k); step();
        end
        pin_addr = H - 1; pin_data = DW'(H - 1);
        run_until_idle(100);
        chk("ovf_sticky", 32'(overflow), 1);
        start_frame();
        chk("next_start_clears", 32'(overflow), 0);

        // Reset mid-drain at address 1000, then a fresh frame.
        fill_sim(1);
        wait_addr(1000);
        rst = 1; step(); rst = 0;
        chk_zero("reset_drain");
        start_frame();
        fill_sim(1);
        begin
            int n = 0;
            while (!rd_valid && n < 10) begin step(); n++; end
            chk("fresh_first_addr", 32'(rd_addr), 0);
            chk("fresh_first_valid", 32'(rd_valid), 1);
        end
        run_until_idle(100);

        // Randomized back-to-back frames with stray strobes and random backpressure.
        for (int f = 0; f < 2; f++) begin
            int n = 0;
            start_frame();
            do begin
                result1 = ($urandom_range(3) != 0); output_result1 = DW'($urandom);
                result2 = ($urandom_range(3) != 0); output_result2 = DW'($urandom);
                rd_ready = ($urandom_range(7) != 0);
                step();
                n++;
            end while (busy && n < 30000);
            quiet();
            if (busy) chk("rand_timeout", 32'(busy), 0);
            chk("rand_fd_pulses", 32'(fd_seen), 1);
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_frame_collector.md
# result_frame_collector

Downstream stage of the dual-lane 3x3 kernel engine on the 64x64 split pipeline. Captures the two independent result streams (lane 1: pixels 0..2047, lane 2: pixels 2048..4095, each in raster order) into a two-bank frame buffer. Once both halves are complete, it replays the whole 4096-pixel frame in address order over a valid/ready read port.

## Interface

Parameters:
- DATA_W, 13, result word width
- ADDR_W, 12, frame address width
- HALF, 2048, results per lane per frame

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  arms a new frame; honoured only in IDLE
- result1  in  1  lane-1 result strobe, one cycle per word
- output_result1  in  DATA_W  lane-1 result word, sampled when result1=1
- result2  in  1  lane-2 result strobe
- output_result2  in  DATA_W  lane-2 result word, sampled when result2=1
- busy  out  1  high in COLLECT and DRAIN
- frame_done  out  1  one-cycle pulse when both lanes hold HALF words
- overflow  out  1  sticky error: a strobe arrived that could not be stored
- rd_valid  out  1  rd_data/rd_addr valid
- rd_ready  in  1  consumer accepts the word when rd_valid&rd_ready
- rd_data  out  DATA_W  frame word
- rd_addr  out  ADDR_W  frame address of rd_data
- rd_last  out  1  high with the word at address 2*HALF-1

## Operation

- Storage: bank0 (HALF x DATA_W) holds lane 1 and bank1 holds lane 2. Each bank has one write port and one synchronous read port, so both lanes can write in the same cycle. Frame address a maps to bank a[ADDR_W-1], offset a[ADDR_W-2:0].
- Counters: cnt1 and cnt2 run 0..HALF and act as write offsets. drain_ptr runs 0..2*HALF-1.
- FSM: IDLE -> COLLECT -> DRAIN -> IDLE.
  - IDLE:
    - busy=0.
    - start=1 clears cnt1, cnt2 and overflow, then moves to COLLECT.
    - Any result strobe in IDLE sets overflow; no write.
  - COLLECT:
    - result1 with cnt1<HALF writes bank0[cnt1] and increments cnt1.
    - result1 with cnt1==HALF is dropped and sets overflow. Lane 2 behaves the same way with bank1 and cnt2.
    - On the edge where cnt1 and cnt2 both become HALF (simultaneous final writes included), go to DRAIN and assert frame_done for the following cycle.
    - Lanes complete in any order.
  - DRAIN:
    - Reads words 0..2*HALF-1 in order through a 1-cycle RAM read and a registered output stage with prefetch, giving one word per cycle at full rate.
    - Strobes during DRAIN set overflow and are dropped.
    - The handshake with rd_last=1 returns the FSM to IDLE on the same edge.
- start outside IDLE is ignored.
- rst at any time:
  - FSM goes to IDLE; counters and drain_ptr go to 0.
  - All outputs go to 0: busy, frame_done, overflow, rd_valid, rd_data, rd_addr, rd_last.
  - Bank contents are not cleared.
- overflow stays set until rst or the next accepted start.

## Timing

- Write: a strobe on cycle N is stored at edge N; the counter value is visible at N+1.
- frame_done is high exactly one cycle: the cycle after the final write edge. busy stays high.
- The first rd_valid asserts 2 cycles after frame_done rises, with rd_addr=0.
- With rd_ready held high, consecutive words appear on consecutive cycles with no bubbles. The full drain takes 4096 handshake cycles.
- Backpressure: while rd_valid=1 and rd_ready=0, rd_data, rd_addr and rd_last hold stable. No word is skipped or duplicated.
- rd_valid deasserts on the cycle after the rd_last handshake. busy drops on that same cycle.
- A start on that cycle is honoured (back-to-back frames).

## Test plan

- Reset: assert rst for 3 cycles mid-stream.
  - Response: all outputs 0; the FSM is in IDLE; result strobes before start set overflow=1.
- Full frame, simultaneous lanes: start, then on 2048 consecutive cycles drive result1 with data k and result2 with data 2048+k. Hold rd_ready=1.
  - Response: a single frame_done pulse; rd_data==rd_addr for addresses 0..4095; rd_last only at 4095; busy low afterwards.
- Skewed lanes: lane 2 finishes all 2048 words first; lane 1 strobes every third cycle.
  - Response: frame_done only after lane 1's 2048th write; drained data is correct.
- Backpressure: during the drain, drop rd_ready for 5 cycles at address 100, then toggle it randomly.
  - Response: word 100 is held stable; the sequence stays 0..4095 with no gaps or repeats.
- Overflow: send a 2049th result1 strobe with data 0x1FFF after lane 1 fills.
  - Response: overflow=1; rd_data at address 2047 is unchanged; the next start clears overflow.
- Reset mid-drain: assert rst when rd_addr=1000.
  - Response: outputs are 0 on the next cycle. A fresh start plus a full frame then drains correctly from address 0.
